load_unit: RTL and testbench

Read-side companion to the byte/half/word store path of `Memory`. It accepts one RISC-V load request (LB/LH/LW/LBU/LHU) at a time and issues word-aligned reads to the memory read port. Where an access crosses a word boundary it reads two consecutive words and merges them little-endian. It returns the sign- or zero-extended 32-bit result to the core through a valid/ready handshake.

---
 rtl/load_unit_pkg.sv | 33 +++
 rtl/load_unit_if.sv | 25 ++
 rtl/load_unit_extend.sv | 28 ++
 rtl/load_unit.sv | 111 +++++++++++
 tb/tb_load_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/load_unit_pkg.sv
// Shared load/store definitions: funct3 load codes, load FSM states and access sizing.
package load_unit_pkg;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFirst  = 2'd1,
    StSecond = 2'd2,
    StResp   = 2'd3
  } lu_state_e;

  // Access size in bytes; the low two funct3 bits encode size for loads and stores alike.
  function automatic logic [2:0] size_from_funct3(input logic [2:0] funct3);
    logic [2:0] size;
    unique case (funct3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    return size;
  endfunction

  function automatic logic is_legal_load(input logic [2:0] funct3);
    return (funct3 == LOAD_LB) || (funct3 == LOAD_LH) || (funct3 == LOAD_LW) ||
           (funct3 == LOAD_LBU) || (funct3 == LOAD_LHU);
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Request, memory read port and response signals of the load unit.
interface load_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  logic [2:0]  req_funct3;
  logic [31:0] mem_address;
  logic [31:0] mem_read_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_error;

  modport master (
    output req_valid, req_address, req_funct3, mem_read_data, resp_ready,
    input  req_ready, mem_address, resp_valid, resp_data, resp_error
  );

  modport slave (
    input  req_valid, req_address, req_funct3, mem_read_data, resp_ready,
    output req_ready, mem_address, resp_valid, resp_data, resp_error
  );

endinterface

// File: rtl/load_unit_extend.sv
// load_extend: merges two little-endian words, shifts by the byte offset and extends.
module load_unit_extend
  import load_unit_pkg::*;
(
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [63:0] merged;
  logic [31:0] shifted;

  always_comb begin
    merged  = {word1, word0} >> {offset, 3'b000};
    shifted = merged[31:0];
    unique case (funct3)
      LOAD_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
      LOAD_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
      LOAD_LW:  result = shifted;
      LOAD_LBU: result = {24'h0, shifted[7:0]};
      LOAD_LHU: result = {16'h0, shifted[15:0]};
      default:  result = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// RISC-V load unit: word-aligned reads, two-word merge on boundary crossing, valid/ready response.
module load_unit
  import load_unit_pkg::*;
(
  input logic          clk,
  input logic          reset,
  load_unit_if.slave   bus
);

  lu_state_e   state_q, state_d;
  logic [1:0]  offset_q;
  logic [2:0]  funct3_q;
  logic [31:0] word0_q;
  logic [31:0] mem_addr_q;
  logic [31:0] resp_data_q;
  logic        resp_error_q;

  logic        crosses;
  logic [31:0] ext_word0;
  logic [31:0] ext_word1;
  logic [31:0] ext_result;

  assign crosses = ({1'b0, offset_q} + size_from_funct3(funct3_q)) > 3'd4;

  // In FIRST the live read is word0; in SECOND it is word1 and word0 comes from the capture.
  assign ext_word0 = (state_q == StFirst)  ? bus.mem_read_data : word0_q;
  assign ext_word1 = (state_q == StSecond) ? bus.mem_read_data : 32'h0;

  load_unit_extend u_extend (
    .word0  (ext_word0),
    .word1  (ext_word1),
    .offset (offset_q),
    .funct3 (funct3_q),
    .result (ext_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = is_legal_load(bus.req_funct3) ? StFirst : StResp;
        end
      end
      StFirst:  state_d = crosses ? StSecond : StResp;
      StSecond: state_d = StResp;
      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready   = (state_q == StIdle);
    bus.resp_valid  = (state_q == StResp);
    bus.resp_data   = resp_data_q;
    bus.resp_error  = resp_error_q;
    bus.mem_address = mem_addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset_q     <= 2'b00;
      funct3_q     <= 3'b000;
      word0_q      <= 32'h0;
      mem_addr_q   <= 32'h0;
      resp_data_q  <= 32'h0;
      resp_error_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            offset_q <= bus.req_address[1:0];
            funct3_q <= bus.req_funct3;
            word0_q  <= 32'h0;
            if (is_legal_load(bus.req_funct3)) begin
              mem_addr_q   <= {bus.req_address[31:2], 2'b00};
              resp_error_q <= 1'b0;
            end else begin
              // Illegal code: no memory cycle, mem_address keeps its previous value.
              resp_data_q  <= 32'h0;
              resp_error_q <= 1'b1;
            end
          end
        end
        StFirst: begin
          word0_q <= bus.mem_read_data;
          if (crosses) begin
            mem_addr_q <= mem_addr_q + 32'd4;
          end else begin
            resp_data_q <= ext_result;
          end
        end
        StSecond: resp_data_q <= ext_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: vector table plus backpressure and reset sequences.
module tb_load_unit;
  import load_unit_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] held_addr;

  load_unit_if bus ();

  load_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0000;
      32'h0000_0004: return 32'hABBD_ADEF;
      32'h0000_0008: return 32'h1122_3344;
      32'h0000_0024: return 32'h1234_EFDA;
      32'hFFFF_FFFC: return 32'hCAFE_BABE;
      default:       return 32'h5A5A_5A5A;
    endcase
  endfunction

  assign bus.mem_read_data = mem_model(bus.mem_address);

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    check({v.name, " req_ready"}, {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid   = 1'b1;
    bus.req_address = v.addr;
    bus.req_funct3  = v.funct3;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 8) begin
      check($sformatf("%s mem_addr c%0d", v.name, lat), bus.mem_address,
            (lat == 0) ? v.exp_a0 : v.exp_a1);
      @(posedge clk);
      #1;
      lat++;
    end
    check({v.name, " latency"}, lat, v.exp_lat);
    if (v.exp_lat == 1) held_addr = v.exp_a0;
    if (v.exp_lat == 2) held_addr = v.exp_a1;
    check({v.name, " data"}, bus.resp_data, v.exp_data);
    check({v.name, " error"}, {31'h0, bus.resp_error}, {31'h0, v.exp_err});
    check({v.name, " held addr"}, bus.mem_address, held_addr);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check({v.name, " valid drop"}, {31'h0, bus.resp_valid}, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, {31'h0, bus.req_ready}, 32'h1);
    check({tag, " resp_valid"}, {31'h0, bus.resp_valid}, 32'h0);
    check({tag, " resp_data"}, bus.resp_data, 32'h0);
    check({tag, " resp_error"}, {31'h0, bus.resp_error}, 32'h0);
    check({tag, " mem_address"}, bus.mem_address, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    held_addr = 32'h0;
    bus.req_valid   = 1'b0;
    bus.req_address = 32'h0;
    bus.req_funct3  = 3'b000;
    bus.resp_ready  = 1'b0;

    vecs[0]  = '{"LW 04",     32'h04, LOAD_LW,  32'hABBDADEF, 1'b0, 1, 32'h04, 32'h0};
    vecs[1]  = '{"LH 24",     32'h24, LOAD_LH,  32'hFFFFEFDA, 1'b0, 1, 32'h24, 32'h0};
    vecs[2]  = '{"LHU 26",    32'h26, LOAD_LHU, 32'h00001234, 1'b0, 1, 32'h24, 32'h0};
    vecs[3]  = '{"LB 07",     32'h07, LOAD_LB,  32'hFFFFFFAB, 1'b0, 1, 32'h04, 32'h0};
    vecs[4]  = '{"LBU 07",    32'h07, LOAD_LBU, 32'h000000AB, 1'b0, 1, 32'h04, 32'h0};
    vecs[5]  = '{"LB 08",     32'h08, LOAD_LB,  32'h00000044, 1'b0, 1, 32'h08, 32'h0};
    vecs[6]  = '{"LW 06",     32'h06, LOAD_LW,  32'h3344ABBD, 1'b0, 2, 32'h04, 32'h08};
    vecs[7]  = '{"LH 07",     32'h07, LOAD_LH,  32'h000044AB, 1'b0, 2, 32'h04, 32'h08};
    vecs[8]  = '{"LW wrap",   32'hFFFFFFFE, LOAD_LW, 32'h0000CAFE, 1'b0, 2, 32'hFFFFFFFC,
                 32'h00000000};
    vecs[9]  = '{"ILL 011",   32'h24, 3'b011,   32'h00000000, 1'b1, 0, 32'h0, 32'h0};
    vecs[10] = '{"LHU 07",    32'h07, LOAD_LHU, 32'h000044AB, 1'b0, 2, 32'h04, 32'h08};
    vecs[11] = '{"ILL 111",   32'h04, 3'b111,   32'h00000000, 1'b1, 0, 32'h0, 32'h0};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i]);
    end

    // Backpressure: result held for five cycles while a competing request is ignored.
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_address = 32'h08;
    bus.req_funct3  = LOAD_LW;
    @(posedge clk);
    #1;
    bus.req_address = 32'h04;
    bus.req_funct3  = LOAD_LB;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp valid c%0d", c), {31'h0, bus.resp_valid}, 32'h1);
      check($sformatf("bp data c%0d", c), bus.resp_data, 32'h11223344);
      check($sformatf("bp req_ready c%0d", c), {31'h0, bus.req_ready}, 32'h0);
      @(posedge clk);
      #1;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check("bp consumed", {31'h0, bus.resp_valid}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("bp not queued valid", {31'h0, bus.resp_valid}, 32'h0);
    check("bp not queued ready", {31'h0, bus.req_ready}, 32'h1);
    held_addr = 32'h08;
    run_vec('{"LBU 04", 32'h04, LOAD_LBU, 32'h000000EF, 1'b0, 1, 32'h04, 32'h0});

    // Reset asserted while the second word of a split load is being read.
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_address = 32'h06;
    bus.req_funct3  = LOAD_LW;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst second addr", bus.mem_address, 32'h08);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post rst no resp", {31'h0, bus.resp_valid}, 32'h0);
    held_addr = 32'h0;
    run_vec('{"LW 04 post", 32'h04, LOAD_LW, 32'hABBDADEF, 1'b0, 1, 32'h04, 32'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
